// File: rtl/topk_tracker_pkg.sv
// Shared types for the top-K senone tracker: score type, FSM states, slot payload.
package topk_tracker_pkg;

    localparam int unsigned SCORE_W = 16;
    localparam int unsigned IDX_W   = 8;

    typedef logic signed [SCORE_W-1:0] num;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DRAIN   = 2'd2
    } topk_state_t;

    // One ranked entry of the best-K list
    typedef struct packed {
        logic             vld;
        logic [IDX_W-1:0] idx;
        num               score;
    } slot_t;

    localparam num    SCORE_MIN  = num'(16'h8000);
    localparam slot_t SLOT_RESET = '{vld: 1'b0, idx: '0, score: SCORE_MIN};

endpackage

// File: rtl/topk_tracker_if.sv
// Score-input and drain-output signals of the top-K tracker.
interface topk_tracker_if;
    import topk_tracker_pkg::*;

    logic             new_vector_available;
    logic             new_senone;
    num               current_score;
    logic [IDX_W-1:0] senone_idx;
    logic             last_senone;

    logic             list_ready;
    logic             out_valid;
    logic             out_ready;
    num               out_score;
    logic [IDX_W-1:0] out_idx;
    logic             out_last;
    logic             drain_done;

    // Producer of scores / consumer of the drained list
    modport master (
        output new_vector_available, new_senone, current_score, senone_idx, last_senone,
        output out_ready,
        input  list_ready, out_valid, out_score, out_idx, out_last, drain_done
    );

    // The tracker itself
    modport slave (
        input  new_vector_available, new_senone, current_score, senone_idx, last_senone,
        input  out_ready,
        output list_ready, out_valid, out_score, out_idx, out_last, drain_done
    );

endinterface

// File: rtl/topk_tracker.sv
// Keeps the K best senone scores of a feature vector sorted, then drains them best-first.
module topk_tracker
    import topk_tracker_pkg::*;
#(
    parameter int unsigned K         = 4,
    parameter int unsigned n_senones = 12
) (
    input  logic           clk,
    input  logic           reset,
    topk_tracker_if.slave  bus
);

    localparam int unsigned CNT_W  = $clog2(K + 1);
    localparam bit          CFG_OK = (K >= 2) && (K <= 8) && (n_senones >= 1);

    // n_senones only sizes the upstream scorer; insertions beyond it are still accepted
    if (!CFG_OK) begin : g_bad_cfg
        $error("topk_tracker: K must be 2..8 and n_senones at least 1");
    end

    topk_state_t      state_q, state_d;
    slot_t [K-1:0]    slot_q, slot_d, ins_slot;
    logic  [K-1:0]    ge;
    slot_t            new_slot;
    logic [CNT_W-1:0] rank_q, rank_d, cnt_d;

    logic             list_ready_q, list_ready_d;
    logic             out_valid_q,  out_valid_d;
    num               out_score_q,  out_score_d;
    logic [IDX_W-1:0] out_idx_q,    out_idx_d;
    logic             out_last_q,   out_last_d;
    logic             drain_done_q, drain_done_d;

    assign new_slot = '{vld: 1'b1, idx: bus.senone_idx, score: bus.current_score};

    // Per-slot insert: keep if this slot outranks the newcomer, take the newcomer at the
    // first slot it beats, otherwise shift the slot above down. Equal scores stay ahead.
    for (genvar i = 0; i < K; i++) begin : g_slot
        assign ge[i] = slot_q[i].vld &&
                       ($signed(slot_q[i].score) >= $signed(bus.current_score));
        if (i == 0) begin : g_head
            assign ins_slot[i] = ge[i] ? slot_q[i] : new_slot;
        end else begin : g_body
            assign ins_slot[i] = ge[i] ? slot_q[i] : (ge[i-1] ? new_slot : slot_q[i-1]);
        end
    end

    // Next state, list update and next drain outputs
    always_comb begin
        state_d      = state_q;
        slot_d       = slot_q;
        rank_d       = rank_q;
        list_ready_d = 1'b0;
        drain_done_d = 1'b0;

        if (bus.new_vector_available) begin
            for (int i = 0; i < int'(K); i++) begin
                slot_d[i].vld = 1'b0;
            end
            rank_d  = '0;
            state_d = COLLECT;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = IDLE;
                end
                COLLECT: begin
                    if (bus.new_senone) begin
                        slot_d = ins_slot;
                    end
                    if (bus.last_senone) begin
                        state_d      = DRAIN;
                        rank_d       = '0;
                        list_ready_d = 1'b1;
                        // empty list: drain finishes in its first cycle
                        if (!slot_d[0].vld) begin
                            drain_done_d = 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (!slot_q[0].vld) begin
                        state_d = IDLE;
                    end else if (out_valid_q && bus.out_ready) begin
                        if (out_last_q) begin
                            state_d      = IDLE;
                            drain_done_d = 1'b1;
                        end else begin
                            rank_d = rank_q + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        cnt_d = '0;
        for (int i = 0; i < int'(K); i++) begin
            cnt_d = cnt_d + CNT_W'(slot_d[i].vld);
        end

        out_valid_d = (state_d == DRAIN) && (rank_d < cnt_d);
        out_last_d  = out_valid_d && (rank_d == cnt_d - CNT_W'(1));
        out_score_d = '0;
        out_idx_d   = '0;
        if (out_valid_d) begin
            for (int i = 0; i < int'(K); i++) begin
                if (CNT_W'(i) == rank_d) begin
                    out_score_d = slot_d[i].score;
                    out_idx_d   = slot_d[i].idx;
                end
            end
        end
    end

    // State, list and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            rank_q       <= '0;
            for (int i = 0; i < int'(K); i++) begin
                slot_q[i] <= SLOT_RESET;
            end
            list_ready_q <= 1'b0;
            out_valid_q  <= 1'b0;
            out_score_q  <= '0;
            out_idx_q    <= '0;
            out_last_q   <= 1'b0;
            drain_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            rank_q       <= rank_d;
            slot_q       <= slot_d;
            list_ready_q <= list_ready_d;
            out_valid_q  <= out_valid_d;
            out_score_q  <= out_score_d;
            out_idx_q    <= out_idx_d;
            out_last_q   <= out_last_d;
            drain_done_q <= drain_done_d;
        end
    end

    assign bus.list_ready = list_ready_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_score  = out_score_q;
    assign bus.out_idx    = out_idx_q;
    assign bus.out_last   = out_last_q;
    assign bus.drain_done = drain_done_q;

endmodule

// File: tb/tb_topk_tracker.sv
// Directed bench for topk_tracker: sorting, ties, extremes, back-pressure, aborts, reset.
module tb_topk_tracker;
    import topk_tracker_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   n_chk  = 0;
    int   n_pass = 0;

    logic [15:0] exp_s[$];
    logic [7:0]  exp_i[$];

    topk_tracker_if bus();

    topk_tracker #(.K(4), .n_senones(12)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #10 clk = ~clk;

    // Single comparison point
    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic nva();
        bus.new_vector_available = 1'b1;
        tick();
        bus.new_vector_available = 1'b0;
    endtask

    task automatic send(input logic [15:0] sc, input logic [7:0] idx, input logic last);
        bus.new_senone    = 1'b1;
        bus.current_score = sc;
        bus.senone_idx    = idx;
        bus.last_senone   = last;
        tick();
        bus.new_senone    = 1'b0;
        bus.last_senone   = 1'b0;
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_list_ready"}, 16'(bus.list_ready), 16'd0);
        chk({tag, "_out_valid"},  16'(bus.out_valid),  16'd0);
        chk({tag, "_out_last"},   16'(bus.out_last),   16'd0);
        chk({tag, "_drain_done"}, 16'(bus.drain_done), 16'd0);
        chk({tag, "_out_score"},  bus.out_score,       16'd0);
        chk({tag, "_out_idx"},    16'(bus.out_idx),    16'd0);
    endtask

    // Drain with out_ready high; expects the first entry already presented
    task automatic drain_check(input string tag);
        for (int r = 0; r < exp_s.size(); r++) begin
            chk($sformatf("%s_valid%0d", tag, r), 16'(bus.out_valid), 16'd1);
            chk($sformatf("%s_score%0d", tag, r), bus.out_score, exp_s[r]);
            chk($sformatf("%s_idx%0d", tag, r), 16'(bus.out_idx), 16'(exp_i[r]));
            chk($sformatf("%s_last%0d", tag, r), 16'(bus.out_last),
                16'(r == exp_s.size() - 1));
            bus.out_ready = 1'b1;
            tick();
        end
        bus.out_ready = 1'b0;
        chk({tag, "_done"},       16'(bus.drain_done), 16'd1);
        chk({tag, "_valid_end"},  16'(bus.out_valid),  16'd0);
        tick();
        chk({tag, "_done_pulse"}, 16'(bus.drain_done), 16'd0);
        chk({tag, "_no_extra"},   16'(bus.out_valid),  16'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, timeout expected none");
        $fatal(1, "watchdog");
    end

    initial begin
        reset                    = 1'b1;
        bus.new_vector_available = 1'b0;
        bus.new_senone           = 1'b0;
        bus.current_score        = '0;
        bus.senone_idx           = '0;
        bus.last_senone          = 1'b0;
        bus.out_ready            = 1'b0;
        tick();
        tick();
        chk_idle_outputs("reset");
        reset = 1'b0;
        tick();

        // Sorting, ties (earlier senone first) and dropping beyond K
        nva();
        send(16'd5,     8'd0, 1'b0);
        send(16'hFFFD,  8'd1, 1'b0);
        send(16'd20,    8'd2, 1'b0);
        send(16'd7,     8'd3, 1'b0);
        send(16'd20,    8'd4, 1'b0);
        send(16'hFF9C,  8'd5, 1'b1);
        chk("t1_list_ready", 16'(bus.list_ready), 16'd1);
        chk("t1_done_early", 16'(bus.drain_done), 16'd0);
        exp_s = '{16'd20, 16'd20, 16'd7, 16'd5};
        exp_i = '{8'd2, 8'd4, 8'd3, 8'd0};
        drain_check("t1");

        // Two entries, back-pressure at rank 1
        nva();
        send(16'd10, 8'd7, 1'b0);
        send(16'd3,  8'd8, 1'b1);
        chk("t2_list_ready", 16'(bus.list_ready), 16'd1);
        chk("t2_score0", bus.out_score, 16'd10);
        chk("t2_idx0", 16'(bus.out_idx), 16'd7);
        chk("t2_last0", 16'(bus.out_last), 16'd0);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick();
            chk($sformatf("t2_hold_valid%0d", c), 16'(bus.out_valid), 16'd1);
            chk($sformatf("t2_hold_score%0d", c), bus.out_score, 16'd3);
            chk($sformatf("t2_hold_idx%0d", c), 16'(bus.out_idx), 16'd8);
            chk($sformatf("t2_hold_last%0d", c), 16'(bus.out_last), 16'd1);
        end
        exp_s = '{16'd3};
        exp_i = '{8'd8};
        drain_check("t2");

        // Empty list: list_ready and drain_done together, no valid
        nva();
        bus.last_senone = 1'b1;
        tick();
        bus.last_senone = 1'b0;
        chk("t3_list_ready", 16'(bus.list_ready), 16'd1);
        chk("t3_drain_done", 16'(bus.drain_done), 16'd1);
        chk("t3_valid", 16'(bus.out_valid), 16'd0);
        tick();
        chk("t3_list_ready_pulse", 16'(bus.list_ready), 16'd0);
        chk("t3_drain_done_pulse", 16'(bus.drain_done), 16'd0);
        chk("t3_valid_after", 16'(bus.out_valid), 16'd0);
        // Scores while idle are ignored
        send(16'd42, 8'd1, 1'b1);
        chk("t3_idle_ignored", 16'(bus.list_ready), 16'd0);
        chk("t3_idle_valid", 16'(bus.out_valid), 16'd0);

        // Abort mid-drain with a new vector, then a fresh list
        nva();
        send(16'd1, 8'd1, 1'b0);
        send(16'd2, 8'd2, 1'b0);
        send(16'd3, 8'd3, 1'b1);
        chk("t4_score0", bus.out_score, 16'd3);
        bus.out_ready = 1'b1;
        tick();
        chk("t4_score1", bus.out_score, 16'd2);
        bus.out_ready            = 1'b0;
        bus.new_vector_available = 1'b1;
        tick();
        bus.new_vector_available = 1'b0;
        chk("t4_abort_valid", 16'(bus.out_valid), 16'd0);
        chk("t4_abort_done", 16'(bus.drain_done), 16'd0);
        send(16'd50, 8'd9, 1'b1);
        chk("t4_list_ready", 16'(bus.list_ready), 16'd1);
        exp_s = '{16'd50};
        exp_i = '{8'd9};
        drain_check("t4");

        // Extreme signed values
        nva();
        send(16'h8000, 8'd1, 1'b0);
        send(16'h7FFF, 8'd2, 1'b0);
        send(16'h0000, 8'd3, 1'b1);
        exp_s = '{16'h7FFF, 16'h0000, 16'h8000};
        exp_i = '{8'd2, 8'd3, 8'd1};
        drain_check("t5");

        // Reset during COLLECT discards the list
        nva();
        send(16'd5, 8'd1, 1'b0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk_idle_outputs("t6_rst");
        bus.last_senone = 1'b1;
        tick();
        bus.last_senone = 1'b0;
        chk("t6_no_drain", 16'(bus.list_ready), 16'd0);
        chk("t6_no_done", 16'(bus.drain_done), 16'd0);

        // Reset during DRAIN: outputs cleared, no drain_done
        nva();
        send(16'd9, 8'd4, 1'b1);
        chk("t7_valid", 16'(bus.out_valid), 16'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk_idle_outputs("t7_rst");
        tick();
        chk("t7_no_done", 16'(bus.drain_done), 16'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/topk_tracker.md
TOPK_TRACKER -- requirements
Module: topk_tracker

Interface
REQ-001 SHALL have parameter K, default 4, number of best senones retained (2..8).
REQ-002 SHALL have parameter n_senones, default 12, senones scored per vector.
REQ-003 SHALL have port clk  input  1  system clock (50 MHz); one clock.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port new_vector_available  input  1  pulse; new feature vector, clears list.
REQ-006 SHALL have port new_senone  input  1  pulse; current_score/senone_idx valid (gdp score_ready).
REQ-007 SHALL have port current_score  input  num  signed 16-bit senone score.
REQ-008 SHALL have port senone_idx  input  8  index of current_score.
REQ-009 SHALL have port last_senone  input  1  pulse; final senone of vector.
REQ-010 SHALL have port list_ready  output  1  one-cycle pulse; list frozen, drain starting.
REQ-011 SHALL have port out_valid  output  1  drain entry valid.
REQ-012 SHALL have port out_ready  input  1  consumer (sender) accepts entry.
REQ-013 SHALL have port out_score  output  num  score of current drain entry.
REQ-014 SHALL have port out_idx  output  8  senone index of current drain entry.
REQ-015 SHALL have port out_last  output  1  current entry is final one.
REQ-016 SHALL have port drain_done  output  1  one-cycle pulse; drain complete.

Function
REQ-017 SHALL hold K slots {score, idx, valid}, sorted descending by score, rank 0 = best.
REQ-018 SHALL use FSM states IDLE, COLLECT, DRAIN.
REQ-019 IDLE/COLLECT/DRAIN + new_vector_available SHALL clear all valid bits and enter COLLECT next cycle (abort any drain, out_valid low next cycle).
REQ-020 In COLLECT, new_senone SHALL insert in one cycle: position p = count of valid slots with score >= current_score; slots p..K-2 shift down one; slot K-1 dropped.
REQ-021 p >= K SHALL discard the score (list unchanged).
REQ-022 Ties SHALL rank the earlier-arriving senone higher (new entry never displaces an equal score).
REQ-023 Comparison SHALL be signed 16-bit; 16'h8000 and 16'h7FFF SHALL be handled as ordinary values.
REQ-024 new_senone in IDLE or DRAIN SHALL be ignored.
REQ-025 last_senone in COLLECT SHALL enter DRAIN next cycle; a new_senone in the same cycle SHALL be inserted first.
REQ-026 list_ready SHALL pulse in the first DRAIN cycle.
REQ-027 In DRAIN, out_valid SHALL be high with rank r (r from 0) on out_score/out_idx while r < number of valid slots; r advances on out_valid && out_ready.
REQ-028 out_score/out_idx/out_last SHALL be stable while out_valid && !out_ready.
REQ-029 out_last SHALL be high with the highest-ranked-index valid entry.
REQ-030 Acceptance of out_last entry SHALL pulse drain_done next cycle and return to IDLE.
REQ-031 Zero valid slots in DRAIN SHALL give out_valid never high, list_ready and drain_done both in first DRAIN cycle, then IDLE.
REQ-032 Insertions received exceeding n_senones SHALL still be processed (no count check); n_senones is informational for sizing.

Reset
REQ-033 Reset SHALL force IDLE, all valid bits 0, slot scores 16'h8000, idx 0.
REQ-034 Reset SHALL drive list_ready, out_valid, out_last, drain_done 0; out_score 0, out_idx 0.
REQ-035 Reset mid-COLLECT or mid-DRAIN SHALL discard the list; no drain_done.

Structure
REQ-036 num (logic signed [15:0]) and state enum topk_state_t SHALL live in the shared project package.
REQ-037 Outputs SHALL be registered; the per-slot compare/shift SHALL be a generate loop, no sub-module.

Verification
REQ-038 nva; scores 5,-3,20,7,20,-100 idx 0..5; last on idx5 -> drain (20,2),(20,4),(7,3),(5,0), out_last on 4th, drain_done.
REQ-039 nva; two scores 10,3, last -> two entries (10),(3), out_last on 2nd, no empty slots emitted.
REQ-040 nva; last with no new_senone -> list_ready and drain_done same cycle, out_valid never high.
REQ-041 drain with out_ready held low 5 cycles at rank 1 -> rank 1 held stable, resumes on out_ready.
REQ-042 nva mid-drain after rank 0 accepted -> out_valid low next cycle, COLLECT, new list from scratch, no drain_done.
REQ-043 scores 16'h8000, 16'h7FFF, 0 -> order 7FFF, 0, 8000; reset during COLLECT -> IDLE, outputs 0.
